mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Owns the single unified instruction/data memory port.
- Shares it between the RV32i core and the SPI loader/debug slave.
- Sequences core execution by driving core_select.
  - After reset the SPI side owns memory so a program can be loaded.
  - A start command hands memory to the core.
  - A halt command freezes the core and returns memory to SPI for debug reads and writes.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- SWITCH_CYCLES, 2, idle cycles inserted on every ownership change (minimum 1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- spi_req  input  1  SPI access request, held until spi_gnt
- spi_we  input  1  1 = write, 0 = read; qualified by spi_req
- spi_addr  input  ADDR_W  SPI access address
- spi_wdata  input  DATA_W  SPI write data
- spi_start  input  1  one-cycle pulse: release memory to the core
- spi_halt  input  1  one-cycle pulse: stop the core, give memory to SPI
- spi_gnt  output  1  one-cycle pulse: SPI access issued to memory this cycle
- spi_rvalid  output  1  one-cycle pulse: spi_rdata valid (one cycle after a read grant)
- spi_rdata  output  DATA_W  registered read data for SPI
- core_adr  input  ADDR_W  core address
- core_wdata  input  DATA_W  core write data
- core_memwrite  input  1  core write strobe
- core_rdata  output  DATA_W  read data to the core
- core_select  output  1  core enable; 0 freezes the core control FSM and datapath
- mem_adr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_we  output  1  memory write enable
- mem_rdata  input  DATA_W  memory read data, synchronous, 1-cycle latency
- owner_state  output  2  current FSM state encoding
- run_cycles  output  32  number of cycles spent in RUN since reset

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state = LOAD, core_select = 0.
  - spi_gnt, spi_rvalid, mem_we = 0; spi_rdata = 0; run_cycles = 0; switch counter = 0.
- States:
  - LOAD = 0: SPI owns memory.
  - TO_CORE = 1: switching to core.
  - RUN = 2: core owns memory.
  - TO_SPI = 3: switching to SPI.
- LOAD:
  - mem_* is driven by the SPI side. mem_we = spi_req & spi_we & spi_gnt.
  - spi_gnt = spi_req in the same cycle (combinational). Each granted cycle is one access; the SPI side must drop or change spi_req after seeing spi_gnt.
  - A granted read asserts spi_rvalid on the next cycle, with spi_rdata registered from mem_rdata.
  - spi_start moves to TO_CORE. If spi_start coincides with spi_req, the access is granted first and the transition still happens.
- TO_CORE:
  - mem_we = 0; no grants.
  - Counter loads SWITCH_CYCLES-1 on entry and decrements; at 0 the FSM goes to RUN.
  - Any pending spi_rvalid completes normally during this state.
- RUN:
  - core_select = 1 (registered, asserted from the first RUN cycle).
  - mem_adr = core_adr, mem_wdata = core_wdata, mem_we = core_memwrite.
  - core_rdata = mem_rdata. The core sees the standard 1-cycle synchronous latency.
  - spi_req is ignored and never granted.
  - run_cycles increments every RUN cycle and wraps from 0xFFFFFFFF to 0.
  - spi_halt moves to TO_SPI. core_select drops in the same registered update, so the core holds its current state.
- TO_SPI:
  - core_select = 0, mem_we = 0.
  - Waits SWITCH_CYCLES, then goes to LOAD.
- Pulses outside their state:
  - spi_start outside LOAD is ignored.
  - spi_halt outside RUN is ignored.
  - If spi_start and spi_halt arrive in the same cycle, the one valid for the current state wins; the other is ignored.
- core_rdata: equals mem_rdata in every state. The core only consumes it while core_select = 1.
- Reset mid-operation:
  - Returns to LOAD, clears run_cycles, and kills any outstanding spi_rvalid.
  - Memory contents are untouched.
- mem_we is never asserted in TO_CORE or TO_SPI; this is the guarantee against write collisions during handover.

Decomposition:
- Shared package holds:
  - the state encodings LOAD/TO_CORE/RUN/TO_SPI;
  - ADDR_W/DATA_W defaults;
  - the SWITCH_CYCLES default.
- One natural sub-module: bus_mux, the combinational owner-select mux for mem_adr/mem_wdata/mem_we.
- The FSM, switch counter, read-valid pipeline and run_cycles counter stay in mem_bus_arbiter.

Test Plan:
1. Reset, then an SPI write sequence: writes 0x00500093 to address 0x0 and 0x00108113 to address 0x4 → mem_we pulses twice, spi_gnt pulses twice, core_select stays 0.
2. SPI read of 0x4 in LOAD → spi_gnt on cycle N, spi_rvalid on cycle N+1, spi_rdata = 0x00108113.
3. spi_start pulse → owner_state goes 1 for 2 cycles, then 2; core_select rises on entering RUN; mem_adr follows core_adr = 0x0; run_cycles counts 1, 2, 3...
4. In RUN, assert spi_req with spi_we=1 to 0x8 → no spi_gnt and no mem_we caused by SPI; core_memwrite=1 with core_adr 0x10 → mem_we=1, mem_adr=0x10.
5. spi_halt in RUN → core_select falls the next cycle, mem_we=0 for 2 cycles, state returns to LOAD, run_cycles freezes; an SPI read is then granted.
6. Assert rst in the middle of TO_CORE (and separately during an outstanding SPI read) → state = LOAD immediately, spi_rvalid never asserts, run_cycles = 0, core_select = 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Holds owner-state encodings and default widths/handover length.
// Imported by the arbiter top and its bus mux.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF        = 32;
    localparam int DATA_W_DEF        = 32;
    localparam int SWITCH_CYCLES_DEF = 2;

    // Owner FSM encodings; the numeric values are visible on owner_state.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_TO_CORE = 2'd1,
        ST_RUN     = 2'd2,
        ST_TO_SPI  = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_mux.sv
// Owner-select mux for the memory address, write data and write enable.
// Latency: purely combinational.
// Backpressure: none; write enable is forced low in both handover states.
module mem_bus_arbiter_bus_mux
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  owner_e             owner_i,
    input  logic [ADDR_W-1:0]  spi_adr_i,
    input  logic [DATA_W-1:0]  spi_wdata_i,
    input  logic               spi_we_i,
    input  logic [ADDR_W-1:0]  core_adr_i,
    input  logic [DATA_W-1:0]  core_wdata_i,
    input  logic               core_we_i,
    output logic [ADDR_W-1:0]  mem_adr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic               mem_we_o
);

    // Core drives the port only in RUN; SPI addresses it otherwise, but may write only in LOAD.
    always_comb begin
        mem_adr_o   = spi_adr_i;
        mem_wdata_o = spi_wdata_i;
        mem_we_o    = 1'b0;
        case (owner_i)
            ST_LOAD: mem_we_o = spi_we_i;
            ST_RUN: begin
                mem_adr_o   = core_adr_i;
                mem_wdata_o = core_wdata_i;
                mem_we_o    = core_we_i;
            end
            default: mem_we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between the core and the SPI loader/debug slave.
// Latency: SPI grant same cycle, read data valid one cycle after grant; handover takes SWITCH_CYCLES.
// Backpressure: SPI requests are held until spi_gnt; they are never granted outside LOAD.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_req,
    input  logic               spi_we,
    input  logic [ADDR_W-1:0]  spi_addr,
    input  logic [DATA_W-1:0]  spi_wdata,
    input  logic               spi_start,
    input  logic               spi_halt,
    output logic               spi_gnt,
    output logic               spi_rvalid,
    output logic [DATA_W-1:0]  spi_rdata,
    input  logic [ADDR_W-1:0]  core_adr,
    input  logic [DATA_W-1:0]  core_wdata,
    input  logic               core_memwrite,
    output logic [DATA_W-1:0]  core_rdata,
    output logic               core_select,
    output logic [ADDR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [1:0]         owner_state,
    output logic [31:0]        run_cycles
);

    localparam int CNT_W = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SWITCH_CYCLES - 1);

    owner_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               core_select_q;
    logic [31:0]        run_cycles_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               spi_we_gated;

    // Grant is combinational in LOAD; held low while reset is asserted so reset values apply at once.
    assign spi_gnt      = ~rst & spi_req & (state_q == ST_LOAD);
    assign spi_we_gated = spi_req & spi_we & spi_gnt;

    mem_bus_arbiter_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_mux (
        .owner_i      (state_q),
        .spi_adr_i    (spi_addr),
        .spi_wdata_i  (spi_wdata),
        .spi_we_i     (spi_we_gated),
        .core_adr_i   (core_adr),
        .core_wdata_i (core_wdata),
        .core_we_i    (core_memwrite),
        .mem_adr_o    (mem_adr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we)
    );

    // Owner FSM with handover counter, registered core enable and RUN cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            cnt_q         <= '0;
            core_select_q <= 1'b0;
            run_cycles_q  <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (spi_start) begin
                        state_q <= ST_TO_CORE;
                        cnt_q   <= CNT_INIT;
                    end
                end
                ST_TO_CORE: begin
                    if (cnt_q == '0) begin
                        state_q       <= ST_RUN;
                        core_select_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    run_cycles_q <= run_cycles_q + 32'd1;
                    if (spi_halt) begin
                        state_q       <= ST_TO_SPI;
                        core_select_q <= 1'b0;
                        cnt_q         <= CNT_INIT;
                    end
                end
                ST_TO_SPI: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Read-valid pipeline: a granted SPI read returns one cycle later; data is held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= spi_gnt & ~spi_we;
            if (rvalid_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // The memory output register supplies the data on the valid cycle; rdata_q keeps it stable after.
    assign spi_rdata   = rvalid_q ? mem_rdata : rdata_q;
    assign spi_rvalid  = rvalid_q;
    assign core_rdata  = mem_rdata;
    assign core_select = core_select_q;
    assign owner_state = state_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int SW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_req, spi_we, spi_start, spi_halt;
    logic [31:0] spi_addr, spi_wdata;
    logic        spi_gnt, spi_rvalid;
    logic [31:0] spi_rdata;
    logic [31:0] core_adr, core_wdata, core_rdata;
    logic        core_memwrite, core_select;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  owner_state;
    logic [31:0] run_cycles;

    int checks = 0;
    int failures = 0;
    int exp_run = 0;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_q [$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .SWITCH_CYCLES(SW)) dut (
        .clk(clk), .rst(rst),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_start(spi_start), .spi_halt(spi_halt),
        .spi_gnt(spi_gnt), .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
        .core_adr(core_adr), .core_wdata(core_wdata), .core_memwrite(core_memwrite),
        .core_rdata(core_rdata), .core_select(core_select),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .owner_state(owner_state), .run_cycles(run_cycles)
    );

    // Synchronous single-port memory, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_adr[9:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected SPI read data whenever the DUT presents spi_rvalid, and watches handover rules.
    always @(negedge clk) begin
        if (spi_rvalid === 1'b1) begin
            if (rd_q.size() == 0) chk("rvalid_unexpected", {31'd0, spi_rvalid}, 32'd0);
            else chk("spi_rdata", spi_rdata, rd_q.pop_front());
        end
        if (owner_state == 2'd1 || owner_state == 2'd3) chk("handover_mem_we", {31'd0, mem_we}, 32'd0);
        if (owner_state != 2'd0) chk("gnt_outside_load", {31'd0, spi_gnt}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // One SPI access in LOAD: grant this cycle, rvalid next cycle for reads.
    task automatic spi_access(input logic we, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a;
        a = addr;
        spi_req = 1'b1; spi_we = we; spi_addr = addr; spi_wdata = data;
        @(negedge clk);
        chk("spi_gnt", {31'd0, spi_gnt}, 32'd1);
        chk("spi_mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("spi_mem_adr", mem_adr, addr);
        chk("core_select_load", {31'd0, core_select}, 32'd0);
        if (we) ref_mem[a[9:2]] = data;
        else rd_q.push_back(ref_mem[a[9:2]]);
        tick();
        spi_req = 1'b0;
        @(negedge clk);
        chk("spi_rvalid", {31'd0, spi_rvalid}, {31'd0, ~we});
        tick();
    endtask

    // Start the core, run it for n cycles with random core/SPI traffic, then halt back to LOAD.
    task automatic run_session(input int n);
        logic [31:0] a, prev_a;
        logic        prev_rd;
        // start coincides with an SPI write, which must still be granted
        a = rand_addr();
        spi_start = 1'b1; spi_halt = 1'($urandom_range(0, 1));
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = a; spi_wdata = $urandom;
        @(negedge clk);
        chk("start_gnt", {31'd0, spi_gnt}, 32'd1);
        chk("start_state", {30'd0, owner_state}, 32'd0);
        ref_mem[a[9:2]] = spi_wdata;
        tick();
        spi_start = 1'b0; spi_halt = 1'b0; spi_addr = 32'h8;
        for (int i = 0; i < SW; i++) begin
            spi_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("to_core_state", {30'd0, owner_state}, 32'd1);
            chk("to_core_sel", {31'd0, core_select}, 32'd0);
            tick();
        end
        prev_rd = 1'b0; prev_a = '0;
        for (int i = 0; i < n; i++) begin
            core_adr = (i == 0) ? 32'h0 : (i == 1) ? 32'h10 : rand_addr();
            core_memwrite = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            core_wdata = $urandom;
            spi_req = 1'($urandom_range(0, 1)); spi_we = 1'b1; spi_addr = 32'h8;
            spi_start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("run_state", {30'd0, owner_state}, 32'd2);
            chk("run_sel", {31'd0, core_select}, 32'd1);
            chk("run_cycles", run_cycles, 32'(exp_run));
            chk("run_mem_adr", mem_adr, core_adr);
            chk("run_mem_we", {31'd0, mem_we}, {31'd0, core_memwrite});
            if (core_memwrite) chk("run_mem_wdata", mem_wdata, core_wdata);
            if (prev_rd) chk("core_rdata", core_rdata, ref_mem[prev_a[9:2]]);
            prev_rd = ~core_memwrite; prev_a = core_adr;
            if (core_memwrite) ref_mem[core_adr[9:2]] = core_wdata;
            tick();
            exp_run++;
        end
        // halt cycle, a stray start alongside is ignored
        spi_halt = 1'b1; spi_start = 1'($urandom_range(0, 1)); spi_req = 1'b0;
        core_memwrite = 1'b0; core_adr = rand_addr();
        @(negedge clk);
        chk("halt_state", {30'd0, owner_state}, 32'd2);
        prev_a = core_adr;
        tick();
        exp_run++;
        spi_halt = 1'b0; spi_start = 1'b0;
        core_memwrite = 1'b1;
        for (int i = 0; i < SW; i++) begin
            @(negedge clk);
            chk("to_spi_state", {30'd0, owner_state}, 32'd3);
            chk("to_spi_sel", {31'd0, core_select}, 32'd0);
            chk("to_spi_mem_we", {31'd0, mem_we}, 32'd0);
            chk("to_spi_run_cycles", run_cycles, 32'(exp_run));
            if (i == 0) chk("core_rdata_halt", core_rdata, ref_mem[prev_a[9:2]]);
            tick();
        end
        core_memwrite = 1'b0;
        @(negedge clk);
        chk("back_to_load", {30'd0, owner_state}, 32'd0);
        chk("frozen_run_cycles", run_cycles, 32'(exp_run));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = '0; spi_wdata = '0;
        spi_start = 1'b0; spi_halt = 1'b0;
        core_adr = '0; core_wdata = '0; core_memwrite = 1'b0;
        #1;
        chk("rst_state", {30'd0, owner_state}, 32'd0);
        chk("rst_sel", {31'd0, core_select}, 32'd0);
        chk("rst_gnt", {31'd0, spi_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rvalid", {31'd0, spi_rvalid}, 32'd0);
        chk("rst_rdata", spi_rdata, 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        spi_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // program load and readback
        spi_access(1'b1, 32'h0, 32'h00500093);
        spi_access(1'b1, 32'h4, 32'h00108113);
        spi_access(1'b0, 32'h4, 32'h0);

        // halt in LOAD is ignored
        spi_halt = 1'b1;
        tick();
        spi_halt = 1'b0;
        @(negedge clk);
        chk("halt_in_load", {30'd0, owner_state}, 32'd0);
        tick();

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++)
                spi_access(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            run_session($urandom_range(3, 12));
            spi_access(1'b0, rand_addr(), 32'h0);
        end

        // reset in the middle of TO_CORE
        spi_start = 1'b1;
        tick();
        spi_start = 1'b0;
        @(negedge clk);
        chk("pre_rst_state", {30'd0, owner_state}, 32'd1);
        rst = 1'b1;
        #1;
        exp_run = 0;
        chk("rst_tc_state", {30'd0, owner_state}, 32'd0);
        chk("rst_tc_sel", {31'd0, core_select}, 32'd0);
        chk("rst_tc_run_cycles", run_cycles, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // reset while an SPI read is outstanding: its rvalid must never appear
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 32'h4;
        @(negedge clk);
        chk("rd_gnt_before_rst", {31'd0, spi_gnt}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rd_state", {30'd0, owner_state}, 32'd0);
        tick();
        spi_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("killed_rvalid", {31'd0, spi_rvalid}, 32'd0);
            tick();
        end

        // memory survives reset, and a fresh session counts from zero
        spi_access(1'b0, 32'h4, 32'h0);
        run_session(4);
        spi_access(1'b0, 32'h0, 32'h0);

        repeat (3) tick();
        chk("rd_q_drained", rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
